// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, exception codes and default vectors for fetch
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [4:0]  EXC_NONE = 5'd0;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] DEF_TEXT_LO    = 32'h0000_3000;
    localparam logic [31:0] DEF_TEXT_HI    = 32'h0000_6ffc;

endpackage

// File: rtl/fetch_addr_chk.sv
// rtl/fetch_addr_chk.sv - combinational word-alignment and text-range check for an instruction address
module fetch_addr_chk
    import fetch_pkg::*;
#(
    parameter logic [31:0] TEXT_LO = DEF_TEXT_LO,
    parameter logic [31:0] TEXT_HI = DEF_TEXT_HI
) (
    input  logic [31:0] addr,
    output logic        adel
);

    // unsigned compares: addresses above 2^31 must not read as negative
    assign adel = (addr[1:0] != 2'b00) || (addr < TEXT_LO) || (addr > TEXT_HI);

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - F-stage PC sequencer with next-PC arbitration and fetch exception reporting
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
    parameter logic [31:0] TEXT_LO    = DEF_TEXT_LO,
    parameter logic [31:0] TEXT_HI    = DEF_TEXT_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        D_eret,
    input  logic [31:0] EPC,
    input  logic        D_jump,
    input  logic        D_taken,
    input  logic [31:0] D_target,
    input  logic        Stop_F,
    output logic [31:0] PC_F_Out,
    output logic [31:0] PCPlus4_F_Out,
    output logic        F_valid_Out,
    output logic        F_isdelay_Out,
    output logic        F_AdEL_Out,
    output logic [4:0]  F_ExcCode_Out
);

    fetch_state_t st, st_next;
    logic [31:0]  pc_q, pc_next;
    logic         bypass;
    logic         addr_bad;
    logic         adel;

    // eret fills its own slot with EPC, so the fetch address is bypassed this cycle
    assign bypass        = D_eret && !Stop_F;
    assign PC_F_Out      = bypass ? EPC : pc_q;
    assign PCPlus4_F_Out = PC_F_Out + 32'd4;

    fetch_addr_chk #(
        .TEXT_LO (TEXT_LO),
        .TEXT_HI (TEXT_HI)
    ) u_addr_chk (
        .addr (PC_F_Out),
        .adel (addr_bad)
    );

    assign adel = addr_bad && !bypass;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st   <= BOOT;
            pc_q <= RESET_PC;
        end else begin
            st   <= st_next;
            pc_q <= pc_next;
        end
    end

    always_comb begin
        st_next       = st;
        pc_next       = pc_q;
        F_valid_Out   = 1'b0;
        F_AdEL_Out    = 1'b0;
        F_ExcCode_Out = EXC_NONE;
        case (st)
            BOOT: begin
                st_next = RUN;
                if (Req) pc_next = HANDLER_PC;
            end
            RUN: begin
                F_valid_Out = 1'b1;
                if (adel) begin
                    F_AdEL_Out    = 1'b1;
                    F_ExcCode_Out = EXC_ADEL;
                end
                if (Req)          pc_next = HANDLER_PC;
                else if (Stop_F)  pc_next = pc_q;
                else if (adel)    st_next = FAULT;
                else if (D_eret)  pc_next = EPC + 32'd4;
                else if (D_taken) pc_next = D_target;
                else              pc_next = pc_q + 32'd4;
            end
            FAULT: begin
                // parked until CP0 redirects, so the fault is reported only once
                if (Req) begin
                    pc_next = HANDLER_PC;
                    st_next = RUN;
                end else if (bypass) begin
                    pc_next = EPC + 32'd4;
                    st_next = RUN;
                end
            end
            default: st_next = BOOT;
        endcase
    end

    assign F_isdelay_Out = D_jump && F_valid_Out;

endmodule
